// File: rtl/rr_sel_gen_pkg.sv
// Shared constants, state type and helpers for the round-robin mux select generator.
package rr_sel_gen_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    function automatic logic [NUM_CH-1:0] onehot(input logic [SEL_W-1:0] s);
        return 4'b0001 << s;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping mod 4.
module rr_pick
    import rr_sel_gen_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic              any,
    output logic [SEL_W-1:0]  win
);

    logic [NUM_CH-1:0] rot;
    logic [SEL_W-1:0]  off;

    // Rotating right by ptr puts the highest-priority channel at bit 0.
    always_comb begin
        rot = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            rot[i] = req[2'(i) + ptr];
        end
    end

    always_comb begin
        off = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = 2'(i);
            end
        end
    end

    assign any = |req;
    assign win = off + ptr;

endmodule

// File: rtl/rr_sel_gen.sv
// Round-robin arbiter driving the 4:1 mux select, with hold limit and back-to-back grants.
module rr_sel_gen
    import rr_sel_gen_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned CNT_W    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] req,
    input  logic              done,
    output logic [SEL_W-1:0]  sel,
    output logic [NUM_CH-1:0] grant,
    output logic              valid,
    output logic [CNT_W-1:0]  busy_cnt
);

    state_t            state, state_nxt;
    logic [SEL_W-1:0]  ptr, ptr_nxt;
    logic [SEL_W-1:0]  sel_nxt;
    logic [NUM_CH-1:0] grant_nxt;
    logic              valid_nxt;
    logic [CNT_W-1:0]  cnt_nxt;

    logic [SEL_W-1:0]  pick_ptr;
    logic              pick_any;
    logic [SEL_W-1:0]  pick_win;
    logic              hold_hit;
    logic              release_now;

    // While busy the search must already start past the owner so a release re-arbitrates in the same cycle.
    assign pick_ptr    = (state == BUSY) ? sel + 2'd1 : ptr;
    assign hold_hit    = (MAX_HOLD != 0) && (busy_cnt == CNT_W'(MAX_HOLD - 1));
    assign release_now = done || !req[sel] || hold_hit;

    rr_pick u_pick (
        .req (req),
        .ptr (pick_ptr),
        .any (pick_any),
        .win (pick_win)
    );

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        sel_nxt   = sel;
        grant_nxt = grant;
        valid_nxt = valid;
        cnt_nxt   = busy_cnt;

        case (state)
            IDLE: begin
                if (pick_any) begin
                    sel_nxt   = pick_win;
                    grant_nxt = onehot(pick_win);
                    valid_nxt = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (release_now) begin
                    ptr_nxt = sel + 2'd1;
                    cnt_nxt = '0;
                    if (pick_any) begin
                        sel_nxt   = pick_win;
                        grant_nxt = onehot(pick_win);
                    end else begin
                        grant_nxt = '0;
                        valid_nxt = 1'b0;
                        state_nxt = IDLE;
                    end
                end else if (busy_cnt != '1) begin
                    cnt_nxt = busy_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            sel      <= '0;
            grant    <= '0;
            valid    <= 1'b0;
            busy_cnt <= '0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            sel      <= sel_nxt;
            grant    <= grant_nxt;
            valid    <= valid_nxt;
            busy_cnt <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_rr_sel_gen.sv
// Self-checking bench for rr_sel_gen: directed scenarios plus randomized traffic against a queue-free reference model.
module tb_rr_sel_gen;

    localparam int MAX_HOLD = 8;
    localparam int CNT_W    = 4;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    logic [1:0] sel;
    logic [3:0] grant;
    logic       valid;
    logic [3:0] busy_cnt;

    int checks;
    int errors;

    rr_sel_gen #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .done     (done),
        .sel      (sel),
        .grant    (grant),
        .valid    (valid),
        .busy_cnt (busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: owner, search start and hold count kept as plain integers.
    int m_sel, m_ptr, m_cnt;
    bit m_valid;

    function automatic int find_winner(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int w;
        bit rel;
        if (!rst_n) begin
            m_sel = 0; m_ptr = 0; m_cnt = 0; m_valid = 0;
        end else if (!m_valid) begin
            w = find_winner(req, m_ptr);
            if (w >= 0) begin
                m_sel = w; m_valid = 1; m_cnt = 0;
            end
        end else begin
            rel = done || !req[m_sel] || (MAX_HOLD != 0 && m_cnt == MAX_HOLD - 1);
            if (rel) begin
                m_ptr = (m_sel + 1) % 4;
                m_cnt = 0;
                w = find_winner(req, m_ptr);
                if (w >= 0) m_sel = w;
                else m_valid = 0;
            end else if (m_cnt < (1 << CNT_W) - 1) begin
                m_cnt = m_cnt + 1;
            end
        end
    end

    function automatic logic [10:0] model_vec();
        logic [3:0] g;
        g = m_valid ? (4'b0001 << m_sel) : 4'b0000;
        return {m_valid, 2'(m_sel), g, 4'(m_cnt)};
    endfunction

    function automatic logic [6:0] exp_grant(input int s);
        logic [3:0] g;
        g = 4'b0001 << s;
        return {1'b1, 2'(s), g};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; req = '0; done = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = '0; done = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if ({valid, sel, grant, busy_cnt} !== 11'b0) begin
                errors++;
                $display("[TB] FAIL reset_idle cyc=%0d got=%b exp=%b", c, {valid, sel, grant, busy_cnt}, 11'b0);
            end
        end
    endtask

    task automatic test_single();
        req = 4'b0100;
        @(negedge clk);
        checks++;
        if ({valid, sel, grant, busy_cnt} !== {1'b1, 2'd2, 4'b0100, 4'd0}) begin
            errors++;
            $display("[TB] FAIL single_grant got=%b exp=%b", {valid, sel, grant, busy_cnt}, {1'b1, 2'd2, 4'b0100, 4'd0});
        end
        @(negedge clk);
        checks++;
        if ({valid, sel, grant, busy_cnt} !== {1'b1, 2'd2, 4'b0100, 4'd1}) begin
            errors++;
            $display("[TB] FAIL single_hold got=%b exp=%b", {valid, sel, grant, busy_cnt}, {1'b1, 2'd2, 4'b0100, 4'd1});
        end
        done = 1'b1; req = 4'b0000;
        @(negedge clk);
        done = 1'b0;
        checks++;
        if ({valid, sel, grant, busy_cnt} !== {1'b0, 2'd2, 4'b0000, 4'd0}) begin
            errors++;
            $display("[TB] FAIL single_release got=%b exp=%b", {valid, sel, grant, busy_cnt}, {1'b0, 2'd2, 4'b0000, 4'd0});
        end
        // Pointer should now sit at 3, so a full request set picks channel 3 first.
        req = 4'b1111;
        @(negedge clk);
        checks++;
        if ({valid, sel, grant} !== exp_grant(3)) begin
            errors++;
            $display("[TB] FAIL ptr_after_release got=%b exp=%b", {valid, sel, grant}, exp_grant(3));
        end
    endtask

    task automatic test_back_to_back();
        int e;
        e = 3;
        for (int j = 0; j < 8; j++) begin
            done = 1'b1;
            @(negedge clk);
            done = 1'b0;
            e = (e + 1) % 4;
            checks++;
            if ({valid, sel, grant, busy_cnt} !== {exp_grant(e), 4'd0}) begin
                errors++;
                $display("[TB] FAIL b2b_switch j=%0d got=%b exp=%b", j, {valid, sel, grant, busy_cnt}, {exp_grant(e), 4'd0});
            end
            @(negedge clk);
            checks++;
            if ({valid, sel, grant, busy_cnt} !== {exp_grant(e), 4'd1}) begin
                errors++;
                $display("[TB] FAIL b2b_hold j=%0d got=%b exp=%b", j, {valid, sel, grant, busy_cnt}, {exp_grant(e), 4'd1});
            end
        end
        req = '0; done = 1'b1;
        @(negedge clk);
        done = 1'b0;
    endtask

    task automatic test_hold_limit();
        do_reset();
        req = 4'b0011;
        for (int ch = 0; ch < 2; ch++) begin
            for (int k = 0; k < MAX_HOLD; k++) begin
                @(negedge clk);
                checks++;
                if ({valid, sel, grant, busy_cnt} !== {exp_grant(ch), 4'(k)}) begin
                    errors++;
                    $display("[TB] FAIL hold ch=%0d k=%0d got=%b exp=%b", ch, k, {valid, sel, grant, busy_cnt}, {exp_grant(ch), 4'(k)});
                end
            end
        end
        @(negedge clk);
        checks++;
        if ({valid, sel, grant, busy_cnt} !== {exp_grant(0), 4'd0}) begin
            errors++;
            $display("[TB] FAIL hold_return got=%b exp=%b", {valid, sel, grant, busy_cnt}, {exp_grant(0), 4'd0});
        end
    endtask

    task automatic test_wrap();
        do_reset();
        req = 4'b1001;
        @(negedge clk);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        checks++;
        if ({valid, sel, grant} !== exp_grant(3)) begin
            errors++;
            $display("[TB] FAIL wrap_sel3 got=%b exp=%b", {valid, sel, grant}, exp_grant(3));
        end
        req = 4'b0001;
        @(negedge clk);
        checks++;
        if ({valid, sel, grant, busy_cnt} !== {exp_grant(0), 4'd0}) begin
            errors++;
            $display("[TB] FAIL wrap_to0 got=%b exp=%b", {valid, sel, grant, busy_cnt}, {exp_grant(0), 4'd0});
        end
        req = 4'b0000;
        @(negedge clk);
        checks++;
        if ({valid, sel, grant} !== 7'b0_00_0000) begin
            errors++;
            $display("[TB] FAIL wrap_idle got=%b exp=%b", {valid, sel, grant}, 7'b0_00_0000);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 4'b0100;
        @(negedge clk);
        checks++;
        if ({valid, sel, grant} !== exp_grant(2)) begin
            errors++;
            $display("[TB] FAIL midrst_setup got=%b exp=%b", {valid, sel, grant}, exp_grant(2));
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({valid, sel, grant, busy_cnt} !== 11'b0) begin
            errors++;
            $display("[TB] FAIL midrst_async got=%b exp=%b", {valid, sel, grant, busy_cnt}, 11'b0);
        end
        req = 4'b1100;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({valid, sel, grant, busy_cnt} !== {exp_grant(2), 4'd0}) begin
            errors++;
            $display("[TB] FAIL midrst_restart got=%b exp=%b", {valid, sel, grant, busy_cnt}, {exp_grant(2), 4'd0});
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            req  = ($urandom_range(0, 9) == 0) ? 4'b0000 : 4'($urandom);
            done = ($urandom_range(0, 4) == 0);
            @(negedge clk);
            checks++;
            if ({valid, sel, grant, busy_cnt} !== model_vec()) begin
                errors++;
                $display("[TB] FAIL random cyc=%0d req=%b got=%b exp=%b", c, req, {valid, sel, grant, busy_cnt}, model_vec());
            end
        end
        done = 1'b0; req = '0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_hold_limit();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
